// File: rtl/hdmi_pattern_pkg.sv
// Shared definitions for the HDMI test-pattern generator: pattern codes,
// channel masks, the resolution table and the ramp reciprocal helper.
package hdmi_pattern_pkg;

    localparam int COORD_W = 17;

    localparam logic [3:0] PAT_WHITE     = 4'd0;
    localparam logic [3:0] PAT_BLACK     = 4'd1;
    localparam logic [3:0] PAT_RED       = 4'd2;
    localparam logic [3:0] PAT_GREEN     = 4'd3;
    localparam logic [3:0] PAT_BLUE      = 4'd4;
    localparam logic [3:0] PAT_RAMP_R    = 4'd5;
    localparam logic [3:0] PAT_RAMP_G    = 4'd6;
    localparam logic [3:0] PAT_RAMP_B    = 4'd7;
    localparam logic [3:0] PAT_RAMP_GREY = 4'd8;
    localparam logic [3:0] PAT_BARS      = 4'd9;
    localparam logic [3:0] PAT_CHECKER   = 4'd10;
    localparam logic [3:0] PAT_BOX       = 4'd11;
    localparam logic [3:0] PAT_LAST      = PAT_BOX;

    // Channel enable masks, ordered {R,G,B}.
    localparam logic [2:0] RGB_WHITE   = 3'b111;
    localparam logic [2:0] RGB_YELLOW  = 3'b110;
    localparam logic [2:0] RGB_CYAN    = 3'b011;
    localparam logic [2:0] RGB_GREEN   = 3'b010;
    localparam logic [2:0] RGB_MAGENTA = 3'b101;
    localparam logic [2:0] RGB_RED     = 3'b100;
    localparam logic [2:0] RGB_BLUE    = 3'b001;
    localparam logic [2:0] RGB_BLACK   = 3'b000;

    typedef enum logic [1:0] {
        RES_640     = 2'b00,
        RES_1024    = 2'b01,
        RES_800     = 2'b10,
        RES_640_ALT = 2'b11
    } res_code_e;

    function automatic logic [COORD_W-1:0] res_h(logic [1:0] code);
        case (code)
            RES_1024: return COORD_W'(1024);
            RES_800:  return COORD_W'(800);
            default:  return COORD_W'(640);
        endcase
    endfunction

    function automatic logic [COORD_W-1:0] res_v(logic [1:0] code);
        case (code)
            RES_1024: return COORD_W'(768);
            RES_800:  return COORD_W'(600);
            default:  return COORD_W'(480);
        endcase
    endfunction

    // Fixed-point reciprocal so the ramp is a multiply and shift, never a divide.
    function automatic int unsigned recip(int unsigned h_disp, int unsigned color_w);
        return (((32'd1 << color_w) - 32'd1) << 16) / h_disp;
    endfunction

    // Colour-bar order, left to right.
    function automatic logic [2:0] bar_rgb(logic [2:0] idx);
        case (idx)
            3'd0:    return RGB_WHITE;
            3'd1:    return RGB_YELLOW;
            3'd2:    return RGB_CYAN;
            3'd3:    return RGB_GREEN;
            3'd4:    return RGB_MAGENTA;
            3'd5:    return RGB_RED;
            3'd6:    return RGB_BLUE;
            default: return RGB_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/hdmi_box_mover.sv
// Moving-box position: one step per axis each frame start, bouncing off the
// edges of the active area and clamped when the resolution shrinks.
module hdmi_box_mover
    import hdmi_pattern_pkg::*;
#(
    parameter int BOX_SIZE = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               fs,
    input  logic [COORD_W-1:0] h_disp,
    input  logic [COORD_W-1:0] v_disp,
    output logic [COORD_W-1:0] bx,
    output logic [COORD_W-1:0] by
);

    localparam logic [COORD_W-1:0] BOX_C = COORD_W'(BOX_SIZE);

    logic [COORD_W-1:0] bx_q, bx_d, by_q, by_d;
    logic [COORD_W-1:0] h_lim, v_lim;
    logic               dx_q, dx_d, dy_q, dy_d;

    // Clamp into 0..limit, reverse if the next step would leave it, then step.
    function automatic logic [COORD_W:0] axis_step(logic [COORD_W-1:0] pos, logic dir_up,
                                                   logic [COORD_W-1:0] limit);
        logic [COORD_W-1:0] p;
        logic               d;
        p = (pos > limit) ? limit : pos;
        d = dir_up;
        if (limit == '0) return {d, p};
        if (d && p >= limit) d = 1'b0;
        else if (!d && p == '0) d = 1'b1;
        p = d ? p + 1'b1 : p - 1'b1;
        return {d, p};
    endfunction

    // Next position, only moving at frame start.
    always_comb begin
        h_lim = (h_disp > BOX_C) ? h_disp - BOX_C : '0;
        v_lim = (v_disp > BOX_C) ? v_disp - BOX_C : '0;
        {dx_d, bx_d} = {dx_q, bx_q};
        {dy_d, by_d} = {dy_q, by_q};
        if (fs) begin
            {dx_d, bx_d} = axis_step(bx_q, dx_q, h_lim);
            {dy_d, by_d} = axis_step(by_q, dy_q, v_lim);
        end
    end

    // Position and direction registers; reset to the origin moving +/+.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bx_q <= '0;
            by_q <= '0;
            dx_q <= 1'b1;
            dy_q <= 1'b1;
        end else begin
            bx_q <= bx_d;
            by_q <= by_d;
            dx_q <= dx_d;
            dy_q <= dy_d;
        end
    end

    assign bx = bx_q;
    assign by = by_q;

endmodule

// File: rtl/hdmi_pattern_gen.sv
// HDMI test-pattern generator. Per-frame state (pattern, resolution, ramp
// reciprocal) is latched at frame start; pixels flow through a fixed
// three-stage pipeline: coordinate capture, pattern evaluation, output.
module hdmi_pattern_gen
    import hdmi_pattern_pkg::*;
#(
    parameter int COLOR_W     = 8,
    parameter int AUTO_FRAMES = 60,
    parameter int BOX_SIZE    = 64,
    parameter int CHECK_LOG2  = 5
) (
    input  logic                 clk,
    input  logic                 sys_rst_n,
    input  logic [16:0]          pixel_xpos,
    input  logic [16:0]          pixel_ypos,
    input  logic                 de,
    input  logic [3:0]           cs,
    input  logic                 auto_en,
    input  logic [1:0]           Resolution_code,
    output logic [3*COLOR_W-1:0] pixel_data,
    output logic                 de_out,
    output logic [3:0]           pattern_id
);

    localparam int          RECIP_W    = COLOR_W + 16;
    localparam int          PROD_W     = COORD_W + COLOR_W + 16;
    localparam int          CNT_W      = $clog2(AUTO_FRAMES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(AUTO_FRAMES - 1);
    localparam int unsigned RECIP_640  = recip(640, COLOR_W);
    localparam int unsigned RECIP_800  = recip(800, COLOR_W);
    localparam int unsigned RECIP_1024 = recip(1024, COLOR_W);
    localparam logic [COORD_W-1:0] BOX_C = COORD_W'(BOX_SIZE);

    logic                 fs;
    logic [3:0]           pattern_q, pattern_d;
    logic [CNT_W-1:0]     frame_cnt_q, frame_cnt_d;
    logic                 auto_mode_q, auto_mode_d;
    logic [COORD_W-1:0]   h_disp_q, h_disp_d, v_disp_q, v_disp_d;
    logic [RECIP_W-1:0]   recip_q, recip_d;
    logic [COORD_W-1:0]   bx, by;

    logic [COORD_W-1:0]   x1_q, y1_q;
    logic                 de1_q;
    logic [COORD_W-1:0]   bar_w;
    logic [2:0]           bar_idx;
    logic                 in_box;
    logic [PROD_W-1:0]    prod;
    logic                 unused_prod;
    logic [2:0]           mask2_d, mask2_q;
    logic                 ramp2_d, ramp2_q, de2_q;
    logic [COLOR_W-1:0]   ramp_val2_d, ramp_val2_q;
    logic [3*COLOR_W-1:0] pix_d, pix_q;
    logic                 de3_q;

    assign fs = de && (pixel_xpos == '0) && (pixel_ypos == '0);

    // Frame-level next state: only frame start changes pattern or resolution.
    always_comb begin
        pattern_d   = pattern_q;
        frame_cnt_d = frame_cnt_q;
        auto_mode_d = auto_mode_q;
        h_disp_d    = h_disp_q;
        v_disp_d    = v_disp_q;
        recip_d     = recip_q;
        if (fs) begin
            h_disp_d    = res_h(Resolution_code);
            v_disp_d    = res_v(Resolution_code);
            case (Resolution_code)
                RES_1024: recip_d = RECIP_W'(RECIP_1024);
                RES_800:  recip_d = RECIP_W'(RECIP_800);
                default:  recip_d = RECIP_W'(RECIP_640);
            endcase
            auto_mode_d = auto_en;
            if (!auto_en) begin
                pattern_d   = (cs <= PAT_LAST) ? cs : PAT_WHITE;
                frame_cnt_d = '0;
            end else if (!auto_mode_q) begin
                // Entering auto mode keeps the current pattern for a full period.
                frame_cnt_d = '0;
            end else if (frame_cnt_q == CNT_LAST) begin
                frame_cnt_d = '0;
                pattern_d   = (pattern_q == PAT_LAST) ? PAT_WHITE : pattern_q + 4'd1;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

    // Frame-level registers; resolution defaults to 640x480.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pattern_q   <= PAT_WHITE;
            frame_cnt_q <= '0;
            auto_mode_q <= 1'b0;
            h_disp_q    <= COORD_W'(640);
            v_disp_q    <= COORD_W'(480);
            recip_q     <= RECIP_W'(RECIP_640);
        end else begin
            pattern_q   <= pattern_d;
            frame_cnt_q <= frame_cnt_d;
            auto_mode_q <= auto_mode_d;
            h_disp_q    <= h_disp_d;
            v_disp_q    <= v_disp_d;
            recip_q     <= recip_d;
        end
    end

    // The box sees the new resolution in the same cycle it is latched.
    hdmi_box_mover #(.BOX_SIZE(BOX_SIZE)) u_box (
        .clk    (clk),
        .rst_n  (sys_rst_n),
        .fs     (fs),
        .h_disp (h_disp_d),
        .v_disp (v_disp_d),
        .bx     (bx),
        .by     (by)
    );

    // Stage 2 evaluation: channel mask, ramp flag and saturated ramp value.
    always_comb begin
        bar_w   = h_disp_q >> 3;
        bar_idx = 3'd0;
        for (int k = 1; k < 8; k++)
            if (x1_q >= COORD_W'(k) * bar_w) bar_idx = bar_idx + 3'd1;
        in_box  = (x1_q >= bx) && (x1_q < bx + BOX_C) && (y1_q >= by) && (y1_q < by + BOX_C);
        prod    = PROD_W'(x1_q) * PROD_W'(recip_q);
        ramp_val2_d = (x1_q >= h_disp_q) ? {COLOR_W{1'b1}} : prod[16 +: COLOR_W];
        mask2_d = RGB_BLACK;
        ramp2_d = 1'b0;
        case (pattern_q)
            PAT_WHITE:     mask2_d = RGB_WHITE;
            PAT_RED:       mask2_d = RGB_RED;
            PAT_GREEN:     mask2_d = RGB_GREEN;
            PAT_BLUE:      mask2_d = RGB_BLUE;
            PAT_RAMP_R:    begin mask2_d = RGB_RED;   ramp2_d = 1'b1; end
            PAT_RAMP_G:    begin mask2_d = RGB_GREEN; ramp2_d = 1'b1; end
            PAT_RAMP_B:    begin mask2_d = RGB_BLUE;  ramp2_d = 1'b1; end
            PAT_RAMP_GREY: begin mask2_d = RGB_WHITE; ramp2_d = 1'b1; end
            PAT_BARS:      mask2_d = bar_rgb(bar_idx);
            PAT_CHECKER:   mask2_d = (x1_q[CHECK_LOG2] ^ y1_q[CHECK_LOG2]) ? RGB_WHITE : RGB_BLACK;
            PAT_BOX:       mask2_d = in_box ? RGB_WHITE : RGB_BLACK;
            default:       mask2_d = RGB_BLACK;
        endcase
    end

    // Only the in-range slice of the product is ever used.
    assign unused_prod = ^{prod[15:0], prod[PROD_W-1:16+COLOR_W]};

    // Stage 3 output: expand the mask to channel values, blank outside de.
    always_comb begin
        pix_d = '0;
        for (int c = 0; c < 3; c++)
            if (de2_q && mask2_q[c])
                pix_d[c*COLOR_W +: COLOR_W] = ramp2_q ? ramp_val2_q : {COLOR_W{1'b1}};
    end

    // Three pipeline stages; every valid clears on reset.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            x1_q        <= '0;
            y1_q        <= '0;
            de1_q       <= 1'b0;
            mask2_q     <= RGB_BLACK;
            ramp2_q     <= 1'b0;
            ramp_val2_q <= '0;
            de2_q       <= 1'b0;
            pix_q       <= '0;
            de3_q       <= 1'b0;
        end else begin
            x1_q        <= pixel_xpos;
            y1_q        <= pixel_ypos;
            de1_q       <= de;
            mask2_q     <= mask2_d;
            ramp2_q     <= ramp2_d;
            ramp_val2_q <= ramp_val2_d;
            de2_q       <= de1_q;
            pix_q       <= pix_d;
            de3_q       <= de2_q;
        end
    end

    assign pixel_data = pix_q;
    assign de_out     = de3_q;
    assign pattern_id = pattern_q;

endmodule

// File: tb/tb_hdmi_pattern_gen.sv
// Directed bench for hdmi_pattern_gen. Inputs change on the falling edge,
// outputs are sampled on the falling edge three rising edges later.
module tb_hdmi_pattern_gen;

    logic        clk;
    logic        sys_rst_n;
    logic [16:0] xpos, ypos;
    logic        de;
    logic [3:0]  cs;
    logic        auto_en;
    logic [1:0]  res;
    logic [23:0] pixel_data;
    logic        de_out;
    logic [3:0]  pattern_id;

    int vec_cnt;
    int err_cnt;

    hdmi_pattern_gen #(
        .COLOR_W(8), .AUTO_FRAMES(2), .BOX_SIZE(64), .CHECK_LOG2(5)
    ) dut (
        .clk             (clk),
        .sys_rst_n       (sys_rst_n),
        .pixel_xpos      (xpos),
        .pixel_ypos      (ypos),
        .de              (de),
        .cs              (cs),
        .auto_en         (auto_en),
        .Resolution_code (res),
        .pixel_data      (pixel_data),
        .de_out          (de_out),
        .pattern_id      (pattern_id)
    );

    // Clock and watchdog.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt + 1);
        $fatal(1, "timeout");
    end

    // Drive one pixel for one cycle, returning at the next falling edge.
    task automatic drive(input logic [16:0] x, input logic [16:0] y, input logic d);
        xpos = x;
        ypos = y;
        de   = d;
        @(negedge clk);
    endtask

    task automatic idle();
        drive(17'd1, 17'd1, 1'b0);
    endtask

    // Apply one pixel and return the outputs three cycles later.
    task automatic probe(input logic [16:0] x, input logic [16:0] y, input logic d,
                         output logic [23:0] pd, output logic dq);
        drive(x, y, d);
        idle();
        idle();
        pd = pixel_data;
        dq = de_out;
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        sys_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        #1;
        vec_cnt++;
        if (pixel_data !== 24'h0 || de_out !== 1'b0 || pattern_id !== 4'd0) begin
            err_cnt++;
            $display("FAIL reset_state: got pd=%h de_out=%b pid=%0d expected 000000/0/0",
                     pixel_data, de_out, pattern_id);
        end
        @(negedge clk);
        @(negedge clk);
        sys_rst_n = 1'b1;
        idle();
    endtask

    task automatic test_bars();
        logic [16:0] xs[6] = '{17'd0, 17'd79, 17'd80, 17'd160, 17'd320, 17'd639};
        logic [23:0] ex[6] = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'hFF00FF, 24'h000000};
        logic [23:0] pd;
        logic        dq;
        cs = 4'd9; res = 2'b00; auto_en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            probe(xs[i], (i == 0) ? 17'd0 : 17'd3, 1'b1, pd, dq);
            vec_cnt++;
            if (pd !== ex[i] || dq !== 1'b1 || pattern_id !== 4'd9) begin
                err_cnt++;
                $display("FAIL bars x=%0d: got pd=%h de_out=%b pid=%0d expected %h/1/9",
                         xs[i], pd, dq, pattern_id, ex[i]);
            end
        end
        probe(17'd100, 17'd3, 1'b0, pd, dq);
        vec_cnt++;
        if (pd !== 24'h0 || dq !== 1'b0) begin
            err_cnt++;
            $display("FAIL blank_de0: got pd=%h de_out=%b expected 000000/0", pd, dq);
        end
    endtask

    // Ramp table: each row starts a frame with (cs,res) then probes one x.
    task automatic test_ramps();
        logic [3:0]  cs_t[7]  = '{4'd8, 4'd8, 4'd8, 4'd8, 4'd5, 4'd6, 4'd7};
        logic [1:0]  res_t[7] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b11};
        logic [16:0] xs[7]    = '{17'd0, 17'd1023, 17'd1100, 17'd512, 17'd320, 17'd400, 17'd639};
        logic [23:0] ex[7]    = '{24'h000000, 24'hFEFEFE, 24'hFFFFFF, 24'h7F7F7F,
                                  24'h7F0000, 24'h007F00, 24'h0000FE};
        logic [23:0] pd;
        logic        dq;
        for (int i = 0; i < 7; i++) begin
            cs = cs_t[i]; res = res_t[i];
            drive(17'd0, 17'd0, 1'b1);
            probe(xs[i], 17'd7, 1'b1, pd, dq);
            vec_cnt++;
            if (pd !== ex[i]) begin
                err_cnt++;
                $display("FAIL ramp cs=%0d res=%0d x=%0d: got %h expected %h",
                         cs_t[i], res_t[i], xs[i], pd, ex[i]);
            end
        end
    endtask

    // Flat colours and checkerboard, including out-of-range select codes.
    task automatic test_flat_checker();
        logic [3:0]  cs_t[11] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd12, 4'd15,
                                  4'd10, 4'd10, 4'd10, 4'd10};
        logic [3:0]  pid_t[11] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd0,
                                   4'd10, 4'd10, 4'd10, 4'd10};
        logic [16:0] xs[11] = '{17'd5, 17'd5, 17'd5, 17'd5, 17'd5, 17'd5, 17'd5,
                                17'd1, 17'd32, 17'd32, 17'd31};
        logic [16:0] ys[11] = '{17'd2, 17'd2, 17'd2, 17'd2, 17'd2, 17'd2, 17'd2,
                                17'd2, 17'd0, 17'd32, 17'd40};
        logic [23:0] ex[11] = '{24'hFFFFFF, 24'h000000, 24'hFF0000, 24'h00FF00, 24'h0000FF,
                                24'hFFFFFF, 24'hFFFFFF, 24'h000000, 24'hFFFFFF,
                                24'h000000, 24'hFFFFFF};
        logic [23:0] pd;
        logic        dq;
        res = 2'b00;
        for (int i = 0; i < 11; i++) begin
            cs = cs_t[i];
            drive(17'd0, 17'd0, 1'b1);
            probe(xs[i], ys[i], 1'b1, pd, dq);
            vec_cnt++;
            if (pd !== ex[i] || pattern_id !== pid_t[i]) begin
                err_cnt++;
                $display("FAIL flat cs=%0d (%0d,%0d): got pd=%h pid=%0d expected %h/%0d",
                         cs_t[i], xs[i], ys[i], pd, pattern_id, ex[i], pid_t[i]);
            end
        end
    endtask

    task automatic test_cs_mid_frame();
        logic [23:0] pd;
        logic        dq;
        cs = 4'd2; res = 2'b00;
        drive(17'd0, 17'd0, 1'b1);
        cs = 4'd3;
        for (int i = 0; i < 3; i++) begin
            probe(17'(10 + i), 17'd5, 1'b1, pd, dq);
            vec_cnt++;
            if (pd !== 24'hFF0000 || pattern_id !== 4'd2) begin
                err_cnt++;
                $display("FAIL cs_mid_frame %0d: got pd=%h pid=%0d expected ff0000/2",
                         i, pd, pattern_id);
            end
        end
        probe(17'd0, 17'd0, 1'b1, pd, dq);
        vec_cnt++;
        if (pd !== 24'h00FF00 || pattern_id !== 4'd3) begin
            err_cnt++;
            $display("FAIL cs_next_frame: got pd=%h pid=%0d expected 00ff00/3", pd, pattern_id);
        end
    endtask

    task automatic test_auto();
        logic [3:0] exp_pid;
        do_reset();
        cs = 4'd5; res = 2'b00; auto_en = 1'b1;
        for (int f = 1; f <= 25; f++) begin
            drive(17'd0, 17'd0, 1'b1);
            exp_pid = 4'(((f - 1) / 2) % 12);
            vec_cnt++;
            if (pattern_id !== exp_pid) begin
                err_cnt++;
                $display("FAIL auto frame %0d: got pid=%0d expected %0d", f, pattern_id, exp_pid);
            end
            idle();
        end
        auto_en = 1'b0;
    endtask

    task automatic test_box();
        logic [16:0] exp_bx, exp_by;
        logic [16:0] xs[5] = '{17'd552, 17'd551, 17'd615, 17'd616, 17'd552};
        logic [16:0] ys[5] = '{17'd232, 17'd232, 17'd295, 17'd295, 17'd296};
        logic [23:0] ex[5] = '{24'hFFFFFF, 24'h000000, 24'hFFFFFF, 24'h000000, 24'h000000};
        logic [23:0] pd;
        logic        dq;
        do_reset();
        cs = 4'd11; res = 2'b00; auto_en = 1'b0;
        for (int f = 1; f <= 600; f++) begin
            drive(17'd0, 17'd0, 1'b1);
            exp_bx = (f <= 576) ? 17'(f) : 17'(1152 - f);
            exp_by = (f <= 416) ? 17'(f) : 17'(832 - f);
            vec_cnt++;
            if (dut.u_box.bx !== exp_bx || dut.u_box.by !== exp_by) begin
                err_cnt++;
                $display("FAIL box_pos frame %0d: got (%0d,%0d) expected (%0d,%0d)",
                         f, dut.u_box.bx, dut.u_box.by, exp_bx, exp_by);
            end
            idle();
        end
        for (int i = 0; i < 5; i++) begin
            probe(xs[i], ys[i], 1'b1, pd, dq);
            vec_cnt++;
            if (pd !== ex[i]) begin
                err_cnt++;
                $display("FAIL box_pixel (%0d,%0d): got %h expected %h", xs[i], ys[i], pd, ex[i]);
            end
        end
    endtask

    task automatic test_reset_mid_line();
        logic       de_seq[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic       exp_de[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [23:0] exp_pd;
        cs = 4'd2; res = 2'b00;
        drive(17'd0, 17'd0, 1'b1);
        drive(17'd10, 17'd0, 1'b1);
        drive(17'd11, 17'd0, 1'b1);
        drive(17'd12, 17'd0, 1'b1);
        vec_cnt++;
        if (pixel_data !== 24'hFF0000 || de_out !== 1'b1) begin
            err_cnt++;
            $display("FAIL pre_reset: got pd=%h de_out=%b expected ff0000/1", pixel_data, de_out);
        end
        #2;
        sys_rst_n = 1'b0;
        #1;
        vec_cnt++;
        if (pixel_data !== 24'h0 || de_out !== 1'b0 || pattern_id !== 4'd0) begin
            err_cnt++;
            $display("FAIL async_reset: got pd=%h de_out=%b pid=%0d expected 000000/0/0",
                     pixel_data, de_out, pattern_id);
        end
        @(negedge clk);
        sys_rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(17'(20 + i), 17'd4, de_seq[i]);
            exp_pd = exp_de[i] ? 24'hFFFFFF : 24'h0;
            vec_cnt++;
            if (de_out !== exp_de[i] || pixel_data !== exp_pd) begin
                err_cnt++;
                $display("FAIL post_reset cycle %0d: got de_out=%b pd=%h expected %b/%h",
                         i, de_out, pixel_data, exp_de[i], exp_pd);
            end
        end
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        xpos = 17'd1; ypos = 17'd1; de = 1'b0;
        cs = 4'd0; auto_en = 1'b0; res = 2'b00;
        test_reset();
        test_bars();
        test_ramps();
        test_flat_checker();
        test_cs_mid_frame();
        test_auto();
        test_box();
        test_reset_mid_line();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
